// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC types, constants and the one-bit division step
package crc_pkg;

  localparam int CRC_W = 16;
  localparam logic [CRC_W-1:0] CRC16_POLY_DEFAULT = 16'h1021;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_DATA,
    SHIFT_CRC,
    DONE
  } chk_state_t;

  // One MSB-first division step: shift the bit in, fold the polynomial back on carry-out
  function automatic logic [CRC_W-1:0] crc_step(
    input logic [CRC_W-1:0] r,
    input logic             b,
    input logic [CRC_W-1:0] poly
  );
    return {r[CRC_W-2:0], b} ^ (r[CRC_W-1] ? poly : '0);
  endfunction

endpackage

// File: rtl/crc16_checker_if.sv
// rtl/crc16_checker_if.sv - input word and result handshake bundle of the checker
interface crc16_checker_if;
  import crc_pkg::*;

  logic             IN_VALID;
  logic             IN_READY;
  logic [CRC_W-1:0] IN_DATA;
  logic [CRC_W-1:0] IN_CRC;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             CRC_OK;
  logic [CRC_W-1:0] SYNDROME;

  modport master (
    output IN_VALID, IN_DATA, IN_CRC, OUT_READY,
    input  IN_READY, OUT_VALID, CRC_OK, SYNDROME
  );

  modport slave (
    input  IN_VALID, IN_DATA, IN_CRC, OUT_READY,
    output IN_READY, OUT_VALID, CRC_OK, SYNDROME
  );

endinterface

// File: rtl/crc_serial_lfsr.sv
// rtl/crc_serial_lfsr.sv - serial CRC division engine shared by generator and checker
module crc_serial_lfsr
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC16_POLY_DEFAULT,
  parameter logic [CRC_W-1:0] INIT = '0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             load,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] state
);

  // Remainder register: reload to INIT per word, otherwise one division step per enabled bit
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)  state <= INIT;
    else if (load) state <= INIT;
    else if (en)   state <= crc_step(state, bit_in, POLY);
  end

endmodule

// File: rtl/crc16_checker.sv
// rtl/crc16_checker.sv - serial CRC-16 receive checker with result handshake and error count
module crc16_checker
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY  = CRC16_POLY_DEFAULT,
  parameter logic [CRC_W-1:0] INIT  = 16'h0000,
  parameter int               CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  crc16_checker_if.slave   bus,
  input  logic             CLR_ERR,
  output logic [CNT_W-1:0] ERR_COUNT
);

  chk_state_t       state_q, state_d;
  logic [CRC_W-1:0] data_buf, crc_buf;
  logic [4:0]       bit_cnt;
  logic [CRC_W-1:0] lfsr_q, lfsr_next;
  logic [CRC_W-1:0] syndrome_q;
  logic             crc_ok_q, out_valid_q;
  logic [CNT_W-1:0] err_q;
  logic             accept, load, en, bit_in, finish;

  crc_serial_lfsr #(.POLY(POLY), .INIT(INIT)) u_lfsr (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .load   (load),
    .en     (en),
    .bit_in (bit_in),
    .state  (lfsr_q)
  );

  // The remainder after the final CRC bit is needed on the same edge that enters DONE
  assign lfsr_next = crc_step(lfsr_q, bit_in, POLY);

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and per-cycle controls; a counter past 15 is treated as corruption and aborts
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load    = 1'b0;
    en      = 1'b0;
    finish  = 1'b0;
    bit_in  = data_buf[CRC_W-1];
    case (state_q)
      IDLE: begin
        if (bus.IN_VALID) begin
          accept  = 1'b1;
          load    = 1'b1;
          state_d = SHIFT_DATA;
        end
      end
      SHIFT_DATA: begin
        if (bit_cnt[4]) state_d = IDLE;
        else begin
          en = 1'b1;
          if (bit_cnt == 5'd15) state_d = SHIFT_CRC;
        end
      end
      SHIFT_CRC: begin
        bit_in = crc_buf[CRC_W-1];
        if (bit_cnt[4]) state_d = IDLE;
        else begin
          en = 1'b1;
          if (bit_cnt == 5'd15) begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift buffers, bit counter and the held result
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      data_buf    <= '0;
      crc_buf     <= '0;
      bit_cnt     <= '0;
      syndrome_q  <= '0;
      crc_ok_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        data_buf <= bus.IN_DATA;
        crc_buf  <= bus.IN_CRC;
        bit_cnt  <= '0;
      end else if (en) begin
        if (state_q == SHIFT_DATA) data_buf <= data_buf << 1;
        else                       crc_buf  <= crc_buf << 1;
        bit_cnt <= (bit_cnt == 5'd15) ? 5'd0 : bit_cnt + 5'd1;
      end
      if (finish) begin
        syndrome_q  <= lfsr_next;
        crc_ok_q    <= (lfsr_next == '0);
        out_valid_q <= 1'b1;
      end else if (state_q == DONE && bus.OUT_READY) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Saturating failure count; a clear on the same edge as a failure wins
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)     err_q <= '0;
    else if (CLR_ERR) err_q <= '0;
    else if (finish && lfsr_next != '0 && err_q != '1) err_q <= err_q + CNT_W'(1);
  end

  assign bus.IN_READY  = (state_q == IDLE);
  assign bus.OUT_VALID = out_valid_q;
  assign bus.CRC_OK    = crc_ok_q;
  assign bus.SYNDROME  = syndrome_q;
  assign ERR_COUNT     = err_q;

endmodule
